regfile_sb: RTL
===============

Name: regfile_sb

Overview:
Parametrised register file with two combinational read ports and two write ports. Each register carries a busy bit, giving a pending-write scoreboard. It is the CPU's architectural register store: the issue stage marks a destination busy, the writeback stage commits and clears it, and decode reads data plus busy status to detect RAW hazards. Writes are qualified by the writeback phase strobe wr_phase.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; register count NREGS = 2**ADDR_W
ZERO_R0, 1, 1 = register 0 hardwired to zero (writes and marks to it ignored); 0 = register 0 is ordinary

Ports:
clk  in  1  clock, all state updates on rising edge
resetn  in  1  synchronous, active-low reset
wr_phase  in  1  writeback phase strobe; writes commit only when high
raddr1  in  ADDR_W  read port 1 address
raddr2  in  ADDR_W  read port 2 address
rdata1  out  DATA_W  read port 1 data, combinational
rdata2  out  DATA_W  read port 2 data, combinational
rbusy1  out  1  busy bit of raddr1, combinational
rbusy2  out  1  busy bit of raddr2, combinational
we0  in  1  write port 0 enable
waddr0  in  ADDR_W  write port 0 address
wdata0  in  DATA_W  write port 0 data
we1  in  1  write port 1 enable (higher priority)
waddr1  in  ADDR_W  write port 1 address
wdata1  in  DATA_W  write port 1 data
mark_en  in  1  set busy bit of mark_addr
mark_addr  in  ADDR_W  register to mark busy
busy_cnt  out  ADDR_W+1  number of registers currently busy, registered
wconflict  out  1  registered one-cycle pulse: both ports committed to the same address

Behaviour:
- Reset (resetn=0 at edge): all registers 0, all busy bits 0, busy_cnt=0, wconflict=0. Reset overrides any concurrent write or mark.
- Commit: port N commits at the edge when wr_phase & weN. No commit when wr_phase=0, regardless of we.
- Both ports commit to the same address: port 1 data stored; wconflict=1 in the following cycle, otherwise 0.
- Reads: rdata = storage[raddr], combinational. Read of an address being written this cycle returns the old value (bypass only under the optional feature).
- ZERO_R0=1: address 0 reads 0 and rbusy=0. Writes/marks to address 0 are dropped, and a same-address r0 dual commit raises no wconflict.
- Scoreboard, per register at each edge:
  - mark_en & mark_addr==r: busy set.
  - Else if any commit to r: busy cleared.
  - Else: busy held.
  - Mark and commit to the same register in the same cycle: mark wins, so busy stays 1 (new producer in flight).
  - Marking an already-busy register: no change.
  - Commit to a non-busy register: legal; writes data, busy stays 0.
- busy_cnt: registered popcount of busy bits, consistent with the busy bits after the same edge. Range 0..NREGS, or 0..NREGS-1 when ZERO_R0=1. Width ADDR_W+1 so NREGS never wraps.
- Latency: write visible on rdata the cycle after the commit edge. Mark visible on rbusy the cycle after the mark edge.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined:
  - When a commit to raddrN is active this cycle, rdataN returns the committing wdata (port 1 over port 0) and rbusyN=0 unless mark_en targets the same address.
  - ZERO_R0 still forces address 0 to 0.
- Undefined: read ports see stored state only; same-cycle read of a written address returns the old value and old busy bit.

Test Plan:
- Reset, then read all 32 addresses -> rdata1/rdata2=0, rbusy=0, busy_cnt=0.
- wr_phase=1, we0=1, waddr0=5, wdata0=0xDEADBEEF; next cycle raddr1=5 -> rdata1=0xDEADBEEF. Repeat with wr_phase=0 and wdata0=0x1 -> value unchanged.
- Same-cycle dual commit to address 7 (port0=0x11, port1=0x22) -> read 7 gives 0x22; wconflict=1 for exactly one cycle.
- Mark 3, then 9 in consecutive cycles -> busy_cnt 1 then 2, rbusy for 3 = 1. Then in one cycle mark 9 and commit 3 and 9 -> busy_cnt=1, register 9 still busy, register 3 free.
- ZERO_R0=1: commit 0xFFFFFFFF to address 0 and mark 0 -> read 0 returns 0, rbusy=0, busy_cnt unchanged.
- Commit to address 4 with raddr2=4 in the same cycle -> old value without REGFILE_BYPASS_EN, new value with it. Assert resetn=0 mid-sequence with busy registers -> everything cleared next cycle.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Register-file bus: two read ports, two write ports, busy marking and status.
// master drives requests (decode/issue/writeback side), slave is the register file.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wr_phase;
  logic [ADDR_W-1:0] raddr1, raddr2;
  logic [DATA_W-1:0] rdata1, rdata2;
  logic              rbusy1, rbusy2;
  logic              we0, we1;
  logic [ADDR_W-1:0] waddr0, waddr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              mark_en;
  logic [ADDR_W-1:0] mark_addr;
  logic [ADDR_W:0]   busy_cnt;
  logic              wconflict;

  modport master (
    output wr_phase, raddr1, raddr2, we0, waddr0, wdata0, we1, waddr1, wdata1,
           mark_en, mark_addr,
    input  rdata1, rdata2, rbusy1, rbusy2, busy_cnt, wconflict
  );

  modport slave (
    input  wr_phase, raddr1, raddr2, we0, waddr0, wdata0, we1, waddr1, wdata1,
           mark_en, mark_addr,
    output rdata1, rdata2, rbusy1, rbusy2, busy_cnt, wconflict
  );
endinterface

// File: rtl/regfile_sb.sv
// 2R/2W register file with per-register busy scoreboard for RAW hazard detection.
// Define REGFILE_BYPASS_EN to forward same-cycle commits onto the read ports.
module regfile_sb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  regfile_sb_if.slave bus
);
  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] mem [NREGS];
  logic [NREGS-1:0]  busy, busy_nxt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              commit0, commit1;

  // r0 writes are dropped entirely when hardwired, which also suppresses its conflict pulse
  assign commit0 = bus.wr_phase & bus.we0 & ~(ZERO_R0 && bus.waddr0 == '0);
  assign commit1 = bus.wr_phase & bus.we1 & ~(ZERO_R0 && bus.waddr1 == '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else begin
      if (commit0) mem[bus.waddr0] <= bus.wdata0;
      if (commit1) mem[bus.waddr1] <= bus.wdata1;
    end
  end

  // Mark beats commit: a new producer was issued for the register being retired
  for (genvar r = 0; r < NREGS; r++) begin : g_busy
    logic hit_mark, hit_commit;
    assign hit_mark   = bus.mark_en && bus.mark_addr == ADDR_W'(r) && !(ZERO_R0 && r == 0);
    assign hit_commit = (commit0 && bus.waddr0 == ADDR_W'(r)) ||
                        (commit1 && bus.waddr1 == ADDR_W'(r));
    assign busy_nxt[r] = hit_mark ? 1'b1 : (hit_commit ? 1'b0 : busy[r]);
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy          <= '0;
      bus.busy_cnt  <= '0;
      bus.wconflict <= 1'b0;
    end else begin
      busy          <= busy_nxt;
      bus.busy_cnt  <= cnt_nxt;
      bus.wconflict <= commit0 & commit1 & (bus.waddr0 == bus.waddr1);
    end
  end

  logic [1:0][ADDR_W-1:0] raddr;
  logic [1:0][DATA_W-1:0] rdata;
  logic [1:0]             rbusy;

  assign raddr      = {bus.raddr2, bus.raddr1};
  assign bus.rdata1 = rdata[0];
  assign bus.rdata2 = rdata[1];
  assign bus.rbusy1 = rbusy[0];
  assign bus.rbusy2 = rbusy[1];

  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      rdata[p] = mem[raddr[p]];
      rbusy[p] = busy[raddr[p]];
`ifdef REGFILE_BYPASS_EN
      if (commit1 && bus.waddr1 == raddr[p]) begin
        rdata[p] = bus.wdata1;
        rbusy[p] = bus.mark_en && bus.mark_addr == raddr[p];
      end else if (commit0 && bus.waddr0 == raddr[p]) begin
        rdata[p] = bus.wdata0;
        rbusy[p] = bus.mark_en && bus.mark_addr == raddr[p];
      end
`endif
      if (ZERO_R0 && raddr[p] == '0) begin
        rdata[p] = '0;
        rbusy[p] = 1'b0;
      end
    end
  end
endmodule
